// File: rtl/fm_regs_pkg.sv
// Shared definitions for the FM generator register map and the sweep master FSM.
package fm_regs_pkg;

   localparam logic [1:0] ADDR_CARRIER   = 2'd0;
   localparam logic [1:0] ADDR_MOD_FREQ  = 2'd1;
   localparam logic [1:0] ADDR_DEVIATION = 2'd2;

   localparam int unsigned DEFAULT_ACK_TIMEOUT = 15;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_ACK,
      DWELL,
      FINISH,
      RD_REQ,
      RD_WAIT
   } sweep_state_t;

endpackage

// File: rtl/wb_master_xfer.sv
// Single Wishbone pipelined transaction: request, stall hold, ack wait, timeout and
// read-data check. A launch coinciding with an ack chains the next transfer under the same cyc.
module wb_master_xfer #(
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_launch,
   input  logic        i_we,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_done,
   output logic        o_timeout,
   output logic        o_rd_err,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [1:0]  o_wb_addr,
   output logic [31:0] o_wb_data,
   input  logic        i_wb_ack,
   input  logic        i_wb_stall,
   input  logic [31:0] i_wb_data
);

   localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

   logic [TW-1:0] tcnt;

   assign o_done    = o_wb_cyc & i_wb_ack;
   assign o_timeout = o_wb_cyc & ~i_wb_ack & (tcnt == TW'(ACK_TIMEOUT - 1));
   // A read returns the value just written, still held on the data lines.
   assign o_rd_err  = o_done & ~o_wb_we & (i_wb_data != o_wb_data);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_wb_cyc  <= 1'b0;
         o_wb_stb  <= 1'b0;
         o_wb_we   <= 1'b0;
         o_wb_addr <= '0;
         o_wb_data <= '0;
         tcnt      <= '0;
      end else if (i_launch) begin
         o_wb_cyc  <= 1'b1;
         o_wb_stb  <= 1'b1;
         o_wb_we   <= i_we;
         o_wb_addr <= i_addr;
         o_wb_data <= i_wdata;
         tcnt      <= '0;
      end else if (o_done || o_timeout) begin
         o_wb_cyc <= 1'b0;
         o_wb_stb <= 1'b0;
      end else if (o_wb_cyc) begin
         if (!i_wb_stall) o_wb_stb <= 1'b0;
         tcnt <= tcnt + 1'b1;
      end
   end

endmodule

// File: rtl/fm_sweep_wb_master.sv
// Autonomous carrier-frequency sweep master for the FM generator Wishbone slave.
// Define FM_SWEEP_READBACK_EN to read back and verify every written value.
module fm_sweep_wb_master
   import fm_regs_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT  = DEFAULT_ACK_TIMEOUT,
   parameter logic [1:0]  CARRIER_ADDR = ADDR_CARRIER
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_start,
   input  logic        i_abort,
   input  logic [31:0] i_start_inc,
   input  logic [31:0] i_step,
   input  logic [15:0] i_num_steps,
   input  logic [23:0] i_dwell,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [15:0] o_step_idx,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [1:0]  o_wb_addr,
   output logic [31:0] o_wb_data,
   input  logic        i_wb_ack,
   input  logic        i_wb_stall,
   input  logic [31:0] i_wb_data
);

`ifdef FM_SWEEP_READBACK_EN
   localparam bit READBACK = 1'b1;
`else
   localparam bit READBACK = 1'b0;
`endif

   sweep_state_t state_q;
   sweep_state_t post_xfer;
   sweep_state_t xfer_next;
   logic [31:0]  value_q;
   logic [31:0]  step_q;
   logic [15:0]  nsteps_q;
   logic [23:0]  dwell_q;
   logic [23:0]  dcnt_q;
   logic         abort_pend;

   logic         launch;
   logic         launch_we;
   logic [31:0]  launch_data;
   logic         xfer_done;
   logic         xfer_timeout;
   logic         xfer_rd_err;
   logic         in_write;
   logic         last_write;
   logic         stop_req;

   assign in_write   = (state_q == REQ) || (state_q == WAIT_ACK);
   assign last_write = (o_step_idx + 16'd1) == nsteps_q;
   assign stop_req   = abort_pend | i_abort;

   // Zero dwell skips DWELL entirely so the next strobe follows the ack directly.
   always_comb begin
      if (stop_req)             post_xfer = FINISH;
      else if (dwell_q != '0)   post_xfer = DWELL;
      else if (last_write)      post_xfer = FINISH;
      else                      post_xfer = REQ;
      xfer_next = (in_write && READBACK && !stop_req) ? RD_REQ : post_xfer;
   end

   always_comb begin
      launch      = 1'b0;
      launch_we   = 1'b1;
      launch_data = value_q;
      unique case (state_q)
         IDLE: begin
            if (i_start && !i_abort && i_num_steps != '0) begin
               launch      = 1'b1;
               launch_data = i_start_inc;
            end
         end
         REQ, WAIT_ACK, RD_REQ, RD_WAIT: begin
            if (xfer_done && xfer_next == RD_REQ) begin
               launch    = 1'b1;
               launch_we = 1'b0;
            end else if (xfer_done && xfer_next == REQ) begin
               launch      = 1'b1;
               launch_data = in_write ? value_q + step_q : value_q;
            end
         end
         DWELL: begin
            if (!i_abort && dcnt_q == 24'd1 && !last_write) launch = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= IDLE;
         value_q    <= '0;
         step_q     <= '0;
         nsteps_q   <= '0;
         dwell_q    <= '0;
         dcnt_q     <= '0;
         abort_pend <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_err      <= 1'b0;
         o_step_idx <= '0;
      end else begin
         o_done <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (i_start && !i_abort) begin
                  value_q    <= i_start_inc;
                  step_q     <= i_step;
                  nsteps_q   <= i_num_steps;
                  dwell_q    <= i_dwell;
                  abort_pend <= 1'b0;
                  o_err      <= 1'b0;
                  o_step_idx <= '0;
                  o_busy     <= 1'b1;
                  if (i_num_steps == '0) begin
                     state_q <= FINISH;
                     o_done  <= 1'b1;
                  end else begin
                     state_q <= REQ;
                  end
               end
            end
            REQ, WAIT_ACK, RD_REQ, RD_WAIT: begin
               if (i_abort) abort_pend <= 1'b1;
               if (xfer_done) begin
                  if (in_write)         value_q <= value_q + step_q;
                  else if (xfer_rd_err) o_err   <= 1'b1;
                  state_q <= xfer_next;
                  if (xfer_next == FINISH) o_done     <= 1'b1;
                  if (xfer_next == REQ)    o_step_idx <= o_step_idx + 16'd1;
                  if (xfer_next == DWELL)  dcnt_q     <= dwell_q;
               end else if (xfer_timeout) begin
                  o_err   <= 1'b1;
                  o_done  <= 1'b1;
                  state_q <= FINISH;
               end else if (!i_wb_stall) begin
                  if (state_q == REQ)         state_q <= WAIT_ACK;
                  else if (state_q == RD_REQ) state_q <= RD_WAIT;
               end
            end
            DWELL: begin
               if (i_abort || (dcnt_q == 24'd1 && last_write)) begin
                  o_done  <= 1'b1;
                  state_q <= FINISH;
               end else if (dcnt_q == 24'd1) begin
                  o_step_idx <= o_step_idx + 16'd1;
                  state_q    <= REQ;
               end else begin
                  dcnt_q <= dcnt_q - 24'd1;
               end
            end
            FINISH: begin
               o_busy  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   wb_master_xfer #(
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_xfer (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_launch   (launch),
      .i_we       (launch_we),
      .i_addr     (CARRIER_ADDR),
      .i_wdata    (launch_data),
      .o_done     (xfer_done),
      .o_timeout  (xfer_timeout),
      .o_rd_err   (xfer_rd_err),
      .o_wb_cyc   (o_wb_cyc),
      .o_wb_stb   (o_wb_stb),
      .o_wb_we    (o_wb_we),
      .o_wb_addr  (o_wb_addr),
      .o_wb_data  (o_wb_data),
      .i_wb_ack   (i_wb_ack),
      .i_wb_stall (i_wb_stall),
      .i_wb_data  (i_wb_data)
   );

endmodule

// File: tb/tb_fm_sweep_wb_master.sv
// Self-checking bench for fm_sweep_wb_master: registered-ack slave with stall injection
// and a sweep-level reference model of write values and cycle timing.
module tb_fm_sweep_wb_master;

   localparam int unsigned T = 15;

   logic        i_clk       = 1'b0;
   logic        i_reset_n   = 1'b0;
   logic        i_start     = 1'b0;
   logic        i_abort     = 1'b0;
   logic [31:0] i_start_inc = '0;
   logic [31:0] i_step      = '0;
   logic [15:0] i_num_steps = '0;
   logic [23:0] i_dwell     = '0;
   logic        i_wb_ack    = 1'b0;
   logic        i_wb_stall  = 1'b0;
   logic [31:0] i_wb_data;
   logic        o_busy, o_done, o_err;
   logic [15:0] o_step_idx;
   logic        o_wb_cyc, o_wb_stb, o_wb_we;
   logic [1:0]  o_wb_addr;
   logic [31:0] o_wb_data;

   logic [31:0] slave_reg = '0;
   assign i_wb_data = slave_reg;

   fm_sweep_wb_master #(
      .ACK_TIMEOUT  (T),
      .CARRIER_ADDR (2'd0)
   ) dut (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_start     (i_start),
      .i_abort     (i_abort),
      .i_start_inc (i_start_inc),
      .i_step      (i_step),
      .i_num_steps (i_num_steps),
      .i_dwell     (i_dwell),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err),
      .o_step_idx  (o_step_idx),
      .o_wb_cyc    (o_wb_cyc),
      .o_wb_stb    (o_wb_stb),
      .o_wb_we     (o_wb_we),
      .o_wb_addr   (o_wb_addr),
      .o_wb_data   (o_wb_data),
      .i_wb_ack    (i_wb_ack),
      .i_wb_stall  (i_wb_stall),
      .i_wb_data   (i_wb_data)
   );

   always #5 i_clk = ~i_clk;

   int cyc_cnt = 0;
   always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc_cnt);
      end
   endtask

   // Slave responder and bus monitor, evaluated mid-cycle.
   logic [31:0] wr_data_q[$];
   logic [31:0] wr_ctl_q[$];
   logic [31:0] wr_idx_q[$];
   int          wr_stb_q[$];
   int          done_q[$];
   int          cyc_fall   = -1;
   int          stall_wr   = -1;
   int          stall_len  = 0;
   int          stall_left = 0;
   int          wr_seen    = 0;
   bit          ack_en     = 1'b1;
   bit          pend       = 1'b0;
   bit          in_req     = 1'b0;
   bit          prev_cyc   = 1'b0;
   logic [31:0] snap_data;
   logic [2:0]  snap_ctl;

   always @(negedge i_clk) begin
      if (!i_reset_n) begin
         pend       = 1'b0;
         in_req     = 1'b0;
         prev_cyc   = 1'b0;
         i_wb_ack   = 1'b0;
         i_wb_stall = 1'b0;
      end else begin
         i_wb_ack = pend && ack_en;
         pend     = 1'b0;
         if (o_wb_stb) check_val("stb_implies_cyc", {31'd0, o_wb_cyc}, 32'd1);
         if (o_wb_cyc && o_wb_stb) begin
            if (!in_req) begin
               in_req     = 1'b1;
               stall_left = (wr_seen == stall_wr) ? stall_len : 0;
               snap_data  = o_wb_data;
               snap_ctl   = {o_wb_we, o_wb_addr};
               wr_stb_q.push_back(cyc_cnt);
            end else begin
               check_val("stall_hold_data", o_wb_data, snap_data);
               check_val("stall_hold_ctl", {29'd0, o_wb_we, o_wb_addr}, {29'd0, snap_ctl});
            end
            if (stall_left > 0) begin
               i_wb_stall = 1'b1;
               stall_left--;
            end else begin
               i_wb_stall = 1'b0;
               pend       = 1'b1;
               in_req     = 1'b0;
               wr_seen++;
               wr_data_q.push_back(o_wb_data);
               wr_ctl_q.push_back({29'd0, o_wb_we, o_wb_addr});
               wr_idx_q.push_back({16'd0, o_step_idx});
               if (o_wb_we) slave_reg = o_wb_data;
            end
         end else begin
            i_wb_stall = 1'b0;
         end
         if (o_done) done_q.push_back(cyc_cnt);
         if (prev_cyc && !o_wb_cyc) cyc_fall = cyc_cnt;
         prev_cyc = o_wb_cyc;
      end
   end

   task automatic clear_log();
      wr_data_q.delete();
      wr_ctl_q.delete();
      wr_idx_q.delete();
      wr_stb_q.delete();
      done_q.delete();
      wr_seen  = 0;
      cyc_fall = -1;
   endtask

   // Runs one sweep and checks it against the expected write list and timing:
   // write k carries start + k*step; strobes are spaced 2 + dwell + stall cycles apart.
   task automatic run_sweep(input logic [31:0] start, input logic [31:0] step,
                            input int nsteps, input int dwell, input int stall_at,
                            input int stall_cyc, input bit acks, input int abort_at);
      int start_ref, abort_cyc, guard, exp_n, exp_stb, exp_done, stl;
      logic [31:0] exp_v;
      clear_log();
      stall_wr  = stall_at;
      stall_len = stall_cyc;
      ack_en    = acks;
      abort_cyc = -1;
      @(negedge i_clk);
      i_start     = 1'b1;
      i_start_inc = start;
      i_step      = step;
      i_num_steps = nsteps[15:0];
      i_dwell     = dwell[23:0];
      start_ref   = cyc_cnt;
      @(negedge i_clk); #1;
      i_start     = 1'b0;
      i_start_inc = $urandom;
      i_step      = $urandom;
      i_num_steps = 16'($urandom);
      i_dwell     = 24'($urandom);
      check_val("busy_after_start", {31'd0, o_busy}, 32'd1);
      check_val("err_cleared_on_start", {31'd0, o_err}, 32'd0);
      if (abort_at >= 0) begin
         guard = 0;
         while (wr_data_q.size() <= abort_at && guard < 2000) begin
            @(negedge i_clk); #1;
            guard++;
         end
         @(negedge i_clk);
         @(negedge i_clk);
         i_abort   = 1'b1;
         abort_cyc = cyc_cnt;
         @(negedge i_clk);
         i_abort = 1'b0;
         #1;
      end
      guard = 0;
      while (o_busy && guard < 3000) begin
         @(negedge i_clk); #1;
         guard++;
      end
      check_val("sweep_terminates", {31'd0, o_busy}, 32'd0);

      if (!acks)            exp_n = (nsteps > 0) ? 1 : 0;
      else if (abort_at >= 0) exp_n = abort_at + 1;
      else                  exp_n = nsteps;
      check_val("write_count", wr_data_q.size(), exp_n);

      exp_stb  = start_ref + 1;
      exp_done = start_ref + 1;
      for (int k = 0; k < exp_n; k++) begin
         if (k >= wr_data_q.size() || k >= wr_stb_q.size()) break;
         exp_v = start + step * 32'(k);
         check_val("write_data", wr_data_q[k], exp_v);
         check_val("write_addr_we", wr_ctl_q[k], 32'h4);
         check_val("write_step_idx", wr_idx_q[k], k);
         check_val("write_stb_cycle", wr_stb_q[k] - start_ref, exp_stb - start_ref);
         stl      = (k == stall_at) ? stall_cyc : 0;
         exp_done = exp_stb + stl + 2 + dwell;
         exp_stb  = exp_done;
      end
      if (!acks && nsteps > 0) begin
         exp_done = start_ref + 1 + T;
         check_val("timeout_cyc_fall", cyc_fall - start_ref, 1 + T);
      end
      if (abort_cyc >= 0) begin
         exp_done = abort_cyc + 1;
         check_val("abort_step_idx", {16'd0, o_step_idx}, abort_at);
      end
      check_val("done_pulses", done_q.size(), 1);
      check_val("done_cycle", (done_q.size() > 0) ? done_q[0] - start_ref : -1, exp_done - start_ref);
      check_val("err_flag", {31'd0, o_err}, (!acks && nsteps > 0) ? 32'd1 : 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n, d, sa;
      repeat (3) @(negedge i_clk);
      check_val("reset_ctl", {8'd0, o_busy, o_done, o_err, o_step_idx, o_wb_cyc, o_wb_stb,
                             o_wb_we, o_wb_addr}, 32'd0);
      check_val("reset_data", o_wb_data, 32'd0);
      i_reset_n = 1'b1;

      run_sweep(32'd59652324, 32'd1000, 4, 3, -1, 0, 1'b1, -1);
      run_sweep(32'd59652324, 32'd1000, 4, 3, 1, 5, 1'b1, -1);
      run_sweep(32'h0000_1234, 32'd5, 3, 2, -1, 0, 1'b0, -1);
      run_sweep(32'hFFFF_FFF0, 32'h20, 2, 1, -1, 0, 1'b1, -1);
      run_sweep(32'h0100_0000, 32'd77, 10, 5, -1, 0, 1'b1, 1);
      run_sweep(32'hDEAD_BEEF, 32'd1, 0, 4, -1, 0, 1'b1, -1);
      run_sweep(32'h0000_0100, 32'hFFFF_FFFF, 3, 0, 2, 3, 1'b1, -1);

      // Abort and start together: abort wins, nothing starts.
      clear_log();
      @(negedge i_clk);
      i_start     = 1'b1;
      i_abort     = 1'b1;
      i_num_steps = 16'd3;
      i_dwell     = 24'd1;
      @(negedge i_clk);
      i_start = 1'b0;
      i_abort = 1'b0;
      #1;
      check_val("abort_start_busy", {31'd0, o_busy}, 32'd0);
      repeat (4) @(negedge i_clk);
      check_val("abort_start_writes", wr_data_q.size(), 0);
      check_val("abort_start_done", done_q.size(), 0);

      // Reset while a transfer is on the bus.
      clear_log();
      stall_wr = -1;
      ack_en   = 1'b1;
      @(negedge i_clk);
      i_start     = 1'b1;
      i_start_inc = 32'h1357_9BDF;
      i_step      = 32'd3;
      i_num_steps = 16'd5;
      i_dwell     = 24'd10;
      @(negedge i_clk);
      i_start = 1'b0;
      #1;
      check_val("pre_reset_cyc", {31'd0, o_wb_cyc}, 32'd1);
      #2;
      i_reset_n = 1'b0;
      #1;
      check_val("midreset_ctl", {8'd0, o_busy, o_done, o_err, o_step_idx, o_wb_cyc, o_wb_stb,
                                o_wb_we, o_wb_addr}, 32'd0);
      check_val("midreset_data", o_wb_data, 32'd0);
      repeat (2) @(negedge i_clk);
      i_reset_n = 1'b1;
      run_sweep(32'h0000_0042, 32'd17, 3, 2, -1, 0, 1'b1, -1);

      for (int r = 0; r < 10; r++) begin
         n  = int'($urandom_range(0, 5));
         d  = int'($urandom_range(0, 4));
         sa = (n > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
         run_sweep($urandom, $urandom, n, d, sa, int'($urandom_range(1, 4)), 1'b1, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
